// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, FSM state encoding and access-size decode.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } lsu_state_e;

    // Access size in bytes from the low two funct3 bits (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bus between the execute/writeback stages (master) and the load/store unit (slave).
interface lsu_if #(parameter int XLEN = 64);

    logic            req_valid_in;
    logic            req_ready_out;
    logic            req_write_in;
    logic [2:0]      req_funct3_in;
    logic [XLEN-1:0] req_address_in;
    logic [XLEN-1:0] req_store_data_in;
    logic            resp_valid_out;
    logic [XLEN-1:0] resp_load_data_out;
    logic            resp_error_out;

    modport master (
        output req_valid_in, req_write_in, req_funct3_in, req_address_in, req_store_data_in,
        input  req_ready_out, resp_valid_out, resp_load_data_out, resp_error_out
    );

    modport slave (
        input  req_valid_in, req_write_in, req_funct3_in, req_address_in, req_store_data_in,
        output req_ready_out, resp_valid_out, resp_load_data_out, resp_error_out
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte lane alignment: store mask/value spread over two words, and load
// extraction with sign or zero extension from a {hi,lo} word pair.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   lo_i,
    input  logic [XLEN-1:0]   hi_i,
    output logic [15:0]       mask16_o,
    output logic [2*XLEN-1:0] val128_o,
    output logic [XLEN-1:0]   load_data_o
);

    logic [3:0]        size;
    logic [15:0]       sizeMask;
    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   raw;
    logic              signExt;

    always_comb begin
        size        = size_bytes(funct3_i);
        sizeMask    = (16'd1 << size) - 16'd1;
        mask16_o    = sizeMask << off_i;
        val128_o    = {{XLEN{1'b0}}, store_data_i} << {off_i, 3'b000};
        shifted     = {hi_i, lo_i} >> {off_i, 3'b000};
        raw         = shifted[XLEN-1:0];
        signExt     = ~funct3_i[2];
        load_data_o = raw;
        case (funct3_i[1:0])
            LB[1:0]: load_data_o = {{(XLEN-8){signExt & raw[7]}}, raw[7:0]};
            LH[1:0]: load_data_o = {{(XLEN-16){signExt & raw[15]}}, raw[15:0]};
            LW[1:0]: load_data_o = {{(XLEN-32){signExt & raw[31]}}, raw[31:0]};
            default: load_data_o = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time into 64-bit RAM word accesses.
// Build option LSU_MISALIGN_SPLIT_EN enables word-crossing accesses; otherwise misaligned requests error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int XLEN       = 64
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    lsu_if.slave                  bus,
    output logic [ADDR_WIDTH-1:0] ram_address_out,
    output logic [XLEN-1:0]       ram_value_out,
    output logic [7:0]            ram_mask_out,
    output logic                  ram_write_signal_out,
    output logic                  ram_read_signal_out,
    input  logic [XLEN-1:0]       ram_read_value_in
);

    lsu_state_e            state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [2:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic                  error_q, error_d;

    logic [15:0]           mask16;
    logic [2*XLEN-1:0]     val128;
    logic [XLEN-1:0]       alignedLoad;
    logic [XLEN-1:0]       hiWord;
    logic                  reqIllegal;
    logic                  unusedAddr;

    assign unusedAddr = ^bus.req_address_in[XLEN-1:ADDR_WIDTH+3];

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [XLEN-1:0]       hi_q, hi_d;
    logic                  split;
    assign hiWord = hi_q;
    assign split  = |mask16[15:8];
`else
    logic [3:0]            reqSize;
    logic                  unusedUpper;
    assign hiWord      = '0;
    assign reqSize     = size_bytes(bus.req_funct3_in);
    assign unusedUpper = ^{mask16[15:8], val128[2*XLEN-1:XLEN]};
`endif

    // Legality is judged on the live request so an illegal one skips the RAM entirely.
    always_comb begin
        reqIllegal = bus.req_write_in ? bus.req_funct3_in[2] : (bus.req_funct3_in == 3'b111);
`ifndef LSU_MISALIGN_SPLIT_EN
        if ((bus.req_address_in[2:0] & 3'(reqSize - 4'd1)) != 3'd0) begin
            reqIllegal = 1'b1;
        end
`endif
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i     (funct3_q),
        .off_i        (off_q),
        .store_data_i (data_q),
        .lo_i         (lo_q),
        .hi_i         (hiWord),
        .mask16_o     (mask16),
        .val128_o     (val128),
        .load_data_o  (alignedLoad)
    );

    // RAM and response outputs decode only registered state; nothing flows from req_* to ram_*.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        word_d   = word_q;
        data_d   = data_q;
        lo_d     = lo_q;
        error_d  = error_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        hi_d     = hi_q;
`endif
        bus.req_ready_out      = 1'b0;
        bus.resp_valid_out     = 1'b0;
        bus.resp_load_data_out = '0;
        bus.resp_error_out     = 1'b0;
        ram_address_out        = '0;
        ram_value_out          = '0;
        ram_mask_out           = '0;
        ram_write_signal_out   = 1'b0;
        ram_read_signal_out    = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready_out = 1'b1;
                if (bus.req_valid_in) begin
                    write_d  = bus.req_write_in;
                    funct3_d = bus.req_funct3_in;
                    off_d    = bus.req_address_in[2:0];
                    word_d   = bus.req_address_in[ADDR_WIDTH+2:3];
                    data_d   = bus.req_store_data_in;
                    error_d  = reqIllegal;
`ifdef LSU_MISALIGN_SPLIT_EN
                    hi_d     = '0;
`endif
                    state_d  = reqIllegal ? RESP : ACC0;
                end
            end
            ACC0: begin
                ram_address_out      = word_q;
                ram_write_signal_out = write_q;
                ram_read_signal_out  = ~write_q;
                if (write_q) begin
                    ram_mask_out  = mask16[7:0];
                    ram_value_out = val128[XLEN-1:0];
                end else begin
                    lo_d = ram_read_value_in;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d = split ? ACC1 : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                ram_address_out      = word_q + ADDR_WIDTH'(1);
                ram_write_signal_out = write_q;
                ram_read_signal_out  = ~write_q;
                if (write_q) begin
                    ram_mask_out  = mask16[15:8];
                    ram_value_out = val128[2*XLEN-1:XLEN];
                end else begin
                    hi_d = ram_read_value_in;
                end
                state_d = RESP;
            end
`endif
            RESP: begin
                bus.resp_valid_out = 1'b1;
                bus.resp_error_out = error_q;
                if (!write_q && !error_q) begin
                    bus.resp_load_data_out = alignedLoad;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            word_q   <= '0;
            data_q   <= '0;
            lo_q     <= '0;
            error_q  <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            word_q   <= word_d;
            data_q   <= data_d;
            lo_q     <= lo_d;
            error_q  <= error_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_q     <= hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference memory, directed and random requests.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_WIDTH = 10;
    localparam int XLEN       = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.XLEN(XLEN)) bus();

    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [63:0]           ramValue;
    logic [7:0]            ramMask;
    logic                  ramWrite;
    logic                  ramRead;
    logic [63:0]           ramReadValue = '0;

    load_store_unit #(.ADDR_WIDTH(ADDR_WIDTH), .XLEN(XLEN)) dut (
        .clk_in               (clk),
        .reset_in             (reset),
        .bus                  (bus),
        .ram_address_out      (ramAddress),
        .ram_value_out        (ramValue),
        .ram_mask_out         (ramMask),
        .ram_write_signal_out (ramWrite),
        .ram_read_signal_out  (ramRead),
        .ram_read_value_in    (ramReadValue)
    );

    // Word-wide RAM device: byte-masked writes on the rising edge, read data on the falling edge.
    logic [63:0] ramMem [1024];
    always @(posedge clk) begin
        if (ramWrite) begin
            for (int b = 0; b < 8; b++) begin
                if (ramMask[b]) ramMem[ramAddress][8*b +: 8] <= ramValue[8*b +: 8];
            end
        end
    end
    always @(negedge clk) begin
        if (ramRead) ramReadValue <= ramMem[ramAddress];
    end

    // Reference memory is a flat 8 KiB byte array; address bits above 12 wrap away.
    logic [7:0] modelMem [8192];
    int assertCount = 0;
    int failCount   = 0;
    logic [63:0] lastData;
    logic        lastErr;
    int          lastLat;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data);
        int size, off, base, expLat, expAcc, accCount, waitCycles;
        logic illegal, gotResp;
        logic [63:0] expData, v;
        logic [ADDR_WIDTH-1:0] expAddr [2];
        logic [7:0]  expMask [2];
        logic [63:0] expValue [2];
        logic [ADDR_WIDTH-1:0] obsAddr [2];
        logic [7:0]  obsMask [2];
        logic [63:0] obsValue [2];
        logic        obsWr [2];
        logic        obsRd [2];

        size = 1 << f3[1:0];
        off  = int'(addr[2:0]);
        base = int'(addr[12:0]);
        illegal = wr ? f3[2] : (f3 == 3'b111);
`ifndef LSU_MISALIGN_SPLIT_EN
        if ((off % size) != 0) illegal = 1'b1;
`endif
        expAcc = illegal ? 0 : ((off + size > 8) ? 2 : 1);
        expLat = illegal ? 1 : expAcc + 1;
        for (int a = 0; a < 2; a++) begin
            expAddr[a]  = ADDR_WIDTH'((int'(addr[12:3]) + a) % 1024);
            expMask[a]  = '0;
            expValue[a] = '0;
            obsAddr[a] = '0; obsMask[a] = '0; obsValue[a] = '0; obsWr[a] = 1'b0; obsRd[a] = 1'b0;
            for (int b = 0; b < 8; b++) begin
                int rel = 8*a + b - off;
                if (rel >= 0 && rel < 8) expValue[a][8*b +: 8] = data[8*rel +: 8];
                if (wr && rel >= 0 && rel < size) expMask[a][b] = 1'b1;
            end
        end
        expData = '0;
        if (!illegal && !wr) begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = modelMem[(base + i) % 8192];
            if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
            expData = v;
        end
        if (!illegal && wr) begin
            for (int i = 0; i < size; i++) modelMem[(base + i) % 8192] = data[8*i +: 8];
        end

        waitCycles = 0;
        while (!bus.req_ready_out && waitCycles < 10) begin
            @(posedge clk); #1; waitCycles++;
        end
        checkOutput("req_ready", 64'(bus.req_ready_out), 64'd1);
        bus.req_valid_in      = 1'b1;
        bus.req_write_in      = wr;
        bus.req_funct3_in     = f3;
        bus.req_address_in    = addr;
        bus.req_store_data_in = data;
        @(posedge clk); #1;
        bus.req_valid_in      = 1'b0;
        bus.req_write_in      = 1'($urandom);
        bus.req_funct3_in     = 3'($urandom);
        bus.req_address_in    = {$urandom, $urandom};
        bus.req_store_data_in = {$urandom, $urandom};

        accCount = 0; gotResp = 1'b0; lastLat = 0; lastErr = 1'b0; lastData = '0;
        for (int k = 1; k <= 6 && !gotResp; k++) begin
            if (ramWrite || ramRead) begin
                if (accCount < 2) begin
                    obsAddr[accCount] = ramAddress; obsMask[accCount] = ramMask;
                    obsValue[accCount] = ramValue; obsWr[accCount] = ramWrite; obsRd[accCount] = ramRead;
                end
                accCount++;
            end
            if (bus.resp_valid_out) begin
                gotResp = 1'b1; lastLat = k;
                lastErr = bus.resp_error_out; lastData = bus.resp_load_data_out;
            end else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("latency", 64'(lastLat), 64'(expLat));
        checkOutput("resp_error", 64'(lastErr), 64'(illegal));
        checkOutput("access_count", 64'(accCount), 64'(expAcc));
        if (!illegal) checkOutput("resp_data", lastData, expData);
        for (int a = 0; a < expAcc && a < accCount; a++) begin
            checkOutput("ram_address", 64'(obsAddr[a]), 64'(expAddr[a]));
            checkOutput("ram_mask", 64'(obsMask[a]), 64'(expMask[a]));
            checkOutput("ram_write", 64'(obsWr[a]), 64'(wr));
            checkOutput("ram_read", 64'(obsRd[a]), 64'(!wr));
            if (wr) checkOutput("ram_value", obsValue[a], expValue[a]);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, 64'(bus.req_ready_out), 64'd1);
        checkOutput({tag, "_resp_valid"}, 64'(bus.resp_valid_out), 64'd0);
        checkOutput({tag, "_resp_misc"}, {bus.resp_load_data_out[62:0], bus.resp_error_out}, 64'd0);
        checkOutput({tag, "_ram_strobes"}, {62'd0, ramWrite, ramRead}, 64'd0);
        checkOutput({tag, "_ram_bus"}, 64'(ramAddress) | 64'(ramMask) | ramValue, 64'd0);
    endtask

    task automatic applyResetDuringLoad(input logic [63:0] addr);
        int waitCycles = 0;
        while (!bus.req_ready_out && waitCycles < 10) begin
            @(posedge clk); #1; waitCycles++;
        end
        bus.req_valid_in = 1'b1; bus.req_write_in = 1'b0; bus.req_funct3_in = LD; bus.req_address_in = addr;
        @(posedge clk); #1;
        bus.req_valid_in = 1'b0;
        checkOutput("rst_acc0_read", 64'(ramRead), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkIdleOutputs("rst_mid");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("rst_no_resp", 64'(bus.resp_valid_out), 64'd0);
        end
    endtask

    int hotWords [6] = '{0, 1, 2, 1021, 1022, 1023};
    int prefillWords [7] = '{0, 1, 2, 3, 1021, 1022, 1023};
    logic [2:0] allCodes [11] = '{LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD};

    initial begin
        logic [63:0] addr;
        bus.req_valid_in = 1'b0; bus.req_write_in = 1'b0; bus.req_funct3_in = '0;
        bus.req_address_in = '0; bus.req_store_data_in = '0;
        for (int i = 0; i < 8192; i++) modelMem[i] = 8'h00;
        for (int w = 0; w < 1024; w++) ramMem[w] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;

        foreach (prefillWords[i]) applyStimulus(1'b1, SD, 64'(prefillWords[i] * 8), {$urandom, $urandom});

        applyStimulus(1'b1, SD, 64'h0000_0008, 64'h1122334455667788);
        applyStimulus(1'b1, SD, 64'h0, 64'h80);
        applyStimulus(1'b0, LB, 64'h0, 64'h0);
        checkOutput("lb_sign", lastData, 64'hFFFFFFFFFFFFFF80);
        applyStimulus(1'b0, LBU, 64'h0, 64'h0);
        checkOutput("lbu_zero", lastData, 64'h80);
        applyStimulus(1'b1, SB, 64'h11, 64'hA5);
        applyStimulus(1'b1, SH, 64'h14, 64'h8001);
        applyStimulus(1'b0, LHU, 64'h14, 64'h0);
        applyStimulus(1'b0, LWU, 64'h10, 64'h0);
        applyStimulus(1'b0, LH, 64'h14, 64'h0);
        applyStimulus(1'b1, SW, 64'h6, 64'hDEADBEEF);
        applyStimulus(1'b0, LW, 64'h6, 64'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        checkOutput("lw_split_data", lastData, 64'hFFFFFFFFDEADBEEF);
        checkOutput("lw_split_lat", 64'(lastLat), 64'd3);
`else
        checkOutput("lw_misalign_err", 64'(lastErr), 64'd1);
`endif
        applyStimulus(1'b0, LD, 64'h1FF9, 64'h0);
        applyStimulus(1'b1, 3'b100, 64'h20, 64'h1234);
        checkOutput("illegal_store_err", 64'(lastErr), 64'd1);
        checkOutput("illegal_store_lat", 64'(lastLat), 64'd1);
        applyStimulus(1'b0, LH, 64'h1, 64'h0);
        applyStimulus(1'b0, 3'b111, 64'h8, 64'h0);

        applyResetDuringLoad(64'h10);

        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3;
            logic wr;
            addr = {$urandom, $urandom};
            addr[12:3] = 10'(hotWords[$urandom_range(0, 5)]);
            if ($urandom_range(0, 7) == 0) begin
                f3 = 3'($urandom);
                wr = 1'($urandom);
            end else begin
                int c = $urandom_range(0, 10);
                f3 = allCodes[c];
                wr = (c >= 7);
            end
            applyStimulus(wr, f3, addr, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
